// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller for a 5-stage MIPS core.
// Each cycle it decides whether PC, IF/ID, ID/EX and EX/MEM advance, hold,
// flush or take a bubble. It covers load-use stalls, taken-branch and jump
// flushes, and multi-cycle data-memory freezes. It also keeps saturating
// stall and flush performance counters.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   IFID_rs_i/rt_i        source registers of the instruction in ID
//   IFID_IsJump_i         instruction in ID is a jump
//   IDEX_rt_i             rt of the instruction in EX
//   IDEX_MemToReg_i       instruction in EX is a load
//   BranchTaken_i         branch in EX resolved taken
//   EXMEM_MemAcc_i        instruction in MEM accesses data memory
//   *_o control           combinational pipeline-register controls
//   stall_cnt_o           saturating count of cycles with PCWrite_o=0
//   flush_cnt_o           saturating count of cycles with IFID_Flush_o=1
module hazard_ctrl_unit #(
   parameter int unsigned MEM_WAIT_CYCLES = 2,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IFID_rs_i,
   input  logic [4:0]       IFID_rt_i,
   input  logic             IFID_IsJump_i,
   input  logic [4:0]       IDEX_rt_i,
   input  logic             IDEX_MemToReg_i,
   input  logic             BranchTaken_i,
   input  logic             EXMEM_MemAcc_i,
   output logic             PCWrite_o,
   output logic             IFID_Write_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Bubble_o,
   output logic             IDEX_Hold_o,
   output logic             EXMEM_Hold_o,
   output logic             MEMWB_Bubble_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int unsigned WCNT_W = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
   localparam bit          MEM_EN = (MEM_WAIT_CYCLES != 0);
   localparam bit          MEM_ONE = (MEM_WAIT_CYCLES == 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic               served_q, served_d;
   logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

   logic newacc;
   logic freeze;
   logic lduse;

   // Hazard detection terms
   always_comb begin
      newacc = (state_q == ST_RUN) && EXMEM_MemAcc_i && !served_q && MEM_EN;
      freeze = newacc || (state_q == ST_WAIT);
      lduse  = IDEX_MemToReg_i && (IDEX_rt_i != 5'd0) &&
               ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_RUN;
         wcnt_q   <= '0;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         served_q <= served_d;
      end
   end

   // Next-state and prioritised control outputs
   always_comb begin
      state_d        = state_q;
      wcnt_d         = wcnt_q;
      served_d       = served_q;
      PCWrite_o      = 1'b0;
      IFID_Write_o   = 1'b0;
      IFID_Flush_o   = 1'b0;
      IDEX_Bubble_o  = 1'b0;
      IDEX_Hold_o    = 1'b0;
      EXMEM_Hold_o   = 1'b0;
      MEMWB_Bubble_o = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (newacc) begin
               if (MEM_ONE) begin
                  served_d = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = WCNT_W'(MEM_WAIT_CYCLES - 1);
               end
            end else begin
               // The served access has left MEM; the next one freezes in full
               served_d = 1'b0;
            end
         end
         ST_WAIT: begin
            if (wcnt_q == WCNT_W'(1)) begin
               state_d  = ST_RUN;
               wcnt_d   = '0;
               served_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Outputs follow rst_i directly so they drop without waiting for a clock
      if (!rst_i) begin
         IDEX_Bubble_o = 1'b1;
      end else if (freeze) begin
         IDEX_Hold_o    = 1'b1;
         EXMEM_Hold_o   = 1'b1;
         MEMWB_Bubble_o = 1'b1;
      end else if (BranchTaken_i) begin
         PCWrite_o     = 1'b1;
         IFID_Flush_o  = 1'b1;
         IDEX_Bubble_o = 1'b1;
      end else if (lduse) begin
         IDEX_Bubble_o = 1'b1;
      end else if (IFID_IsJump_i) begin
         PCWrite_o    = 1'b1;
         IFID_Flush_o = 1'b1;
      end else begin
         PCWrite_o    = 1'b1;
         IFID_Write_o = 1'b1;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!PCWrite_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (IFID_Flush_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit: a driver applies directed and random
// stimulus, a reference model pushes expected responses into a scoreboard
// queue, and a monitor pops and compares on the falling edge.
module tb_hazard_ctrl_unit;

   localparam int unsigned MWC = 2;

   typedef struct packed {
      logic [6:0]  ctrl;
      logic [15:0] st16;
      logic [15:0] fl16;
      logic [3:0]  st4;
      logic [3:0]  fl4;
   } exp_t;

   logic       clk_i;
   logic       rst_i;
   logic [4:0] IFID_rs_i, IFID_rt_i, IDEX_rt_i;
   logic       IFID_IsJump_i, IDEX_MemToReg_i, BranchTaken_i, EXMEM_MemAcc_i;

   logic        a_pcw, a_ifw, a_fl, a_bub, a_ih, a_eh, a_mb;
   logic [15:0] a_st16, a_fl16;
   logic        b_pcw, b_ifw, b_fl, b_bub, b_ih, b_eh, b_mb;
   logic [3:0]  b_st4, b_fl4;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state: freeze cycles remaining for the access in MEM,
   // whether that access has already been served, and raw event counts
   int frz_left = 0;
   bit done     = 0;
   int n_stall  = 0;
   int n_flush  = 0;

   hazard_ctrl_unit #(.MEM_WAIT_CYCLES(MWC), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .IFID_rs_i(IFID_rs_i), .IFID_rt_i(IFID_rt_i), .IFID_IsJump_i(IFID_IsJump_i),
      .IDEX_rt_i(IDEX_rt_i), .IDEX_MemToReg_i(IDEX_MemToReg_i),
      .BranchTaken_i(BranchTaken_i), .EXMEM_MemAcc_i(EXMEM_MemAcc_i),
      .PCWrite_o(a_pcw), .IFID_Write_o(a_ifw), .IFID_Flush_o(a_fl),
      .IDEX_Bubble_o(a_bub), .IDEX_Hold_o(a_ih), .EXMEM_Hold_o(a_eh),
      .MEMWB_Bubble_o(a_mb), .stall_cnt_o(a_st16), .flush_cnt_o(a_fl16)
   );

   hazard_ctrl_unit #(.MEM_WAIT_CYCLES(MWC), .CNT_W(4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i),
      .IFID_rs_i(IFID_rs_i), .IFID_rt_i(IFID_rt_i), .IFID_IsJump_i(IFID_IsJump_i),
      .IDEX_rt_i(IDEX_rt_i), .IDEX_MemToReg_i(IDEX_MemToReg_i),
      .BranchTaken_i(BranchTaken_i), .EXMEM_MemAcc_i(EXMEM_MemAcc_i),
      .PCWrite_o(b_pcw), .IFID_Write_o(b_ifw), .IFID_Flush_o(b_fl),
      .IDEX_Bubble_o(b_bub), .IDEX_Hold_o(b_ih), .EXMEM_Hold_o(b_eh),
      .MEMWB_Bubble_o(b_mb), .stall_cnt_o(b_st4), .flush_cnt_o(b_fl4)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [15:0] sat16(input int n);
      return (n > 65535) ? 16'hFFFF : 16'(n);
   endfunction

   function automatic logic [3:0] sat4(input int n);
      return (n > 15) ? 4'hF : 4'(n);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // One cycle: drive inputs after the rising edge, push the expected response,
   // then advance the model to the state after the next rising edge.
   task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic jmp, input logic [4:0] xrt, input logic m2r,
                       input logic br, input logic macc);
      exp_t e;
      bit   freeze, lduse;
      @(posedge clk_i);
      #1;
      rst_i = r; IFID_rs_i = rs; IFID_rt_i = rt; IFID_IsJump_i = jmp;
      IDEX_rt_i = xrt; IDEX_MemToReg_i = m2r; BranchTaken_i = br; EXMEM_MemAcc_i = macc;
      if (!r) begin
         frz_left = 0; done = 0; n_stall = 0; n_flush = 0;
         e.ctrl = 7'b0001000;
      end else begin
         if (macc && !done && frz_left == 0 && MWC > 0) frz_left = MWC;
         freeze = (frz_left > 0);
         lduse  = m2r && (xrt != 0) && ((xrt == rs) || (xrt == rt));
         if (freeze)     e.ctrl = 7'b0000111;
         else if (br)    e.ctrl = 7'b1011000;
         else if (lduse) e.ctrl = 7'b0001000;
         else if (jmp)   e.ctrl = 7'b1010000;
         else            e.ctrl = 7'b1100000;
      end
      e.st16 = sat16(n_stall); e.fl16 = sat16(n_flush);
      e.st4  = sat4(n_stall);  e.fl4  = sat4(n_flush);
      sb_q.push_back(e);
      if (r) begin
         if (!e.ctrl[6]) n_stall++;
         if (e.ctrl[4])  n_flush++;
         if (freeze) begin
            frz_left--;
            if (frz_left == 0) done = 1;
         end else begin
            done = 0;
         end
      end
   endtask

   // Monitor: compare every presented cycle against the oldest expectation
   always @(negedge clk_i) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("ctrl", int'({a_pcw, a_ifw, a_fl, a_bub, a_ih, a_eh, a_mb}), int'(e.ctrl));
         chk("ctrl_w4", int'({b_pcw, b_ifw, b_fl, b_bub, b_ih, b_eh, b_mb}), int'(e.ctrl));
         chk("stall_cnt", int'(a_st16), int'(e.st16));
         chk("flush_cnt", int'(a_fl16), int'(e.fl16));
         chk("stall_cnt_w4", int'(b_st4), int'(e.st4));
         chk("flush_cnt_w4", int'(b_fl4), int'(e.fl4));
      end
   end

   initial begin
      rst_i = 1'b0; IFID_rs_i = '0; IFID_rt_i = '0; IFID_IsJump_i = 1'b0;
      IDEX_rt_i = '0; IDEX_MemToReg_i = 1'b0; BranchTaken_i = 1'b0; EXMEM_MemAcc_i = 1'b0;

      // Reset state
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
      // Load-use: lw $2 then add $3,$2,$4
      step(1, 2, 4, 0, 2, 1, 0, 0);
      step(1, 5, 6, 0, 0, 0, 0, 0);
      // Load into $0 never stalls
      step(1, 0, 0, 0, 0, 1, 0, 0);
      // Taken branch wins over load-use
      step(1, 2, 4, 0, 2, 1, 1, 0);
      // Jump in ID
      step(1, 1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      // Access held in MEM for three cycles
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // Two back-to-back stores, branch and load-use ignored while frozen
      repeat (6) step(1, 3, 3, 1, 3, 1, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // Reset asserted while in the wait state, then released
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
      // Hold load-use for 20 cycles: 4-bit counter saturates
      repeat (20) step(1, 7, 1, 0, 7, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // Flush saturation in the 4-bit counter
      repeat (20) step(1, 0, 0, 1, 0, 0, 0, 0);

      // Randomised traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) != 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0),
              5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end

      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
